// File: rtl/int_to_fp_seq.sv
// Sequential sign-magnitude integer to {sign, exp[3:0], frac[7:0]} converter with a start/done handshake.
// Define INT2FP_FAST_NORM_EN to normalize in a single NORM cycle via a leading-one encoder and barrel shift.
module int_to_fp_seq #(
  parameter int N_BIT = 8,
  parameter int E_BIT = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [N_BIT-1:0]       int_in,
  output logic                   ready,
  output logic                   done_tick,
  output logic [N_BIT+E_BIT:0]   fp_out
);

  typedef enum logic {IDLE, NORM} state_t;

  state_t               state, state_n;
  logic                 sign_r, sign_n;
  logic                 zero_r, zero_n;
  logic [E_BIT-1:0]     exp_r, exp_n;
  logic [N_BIT-1:0]     frac_r, frac_n;
  logic [N_BIT+E_BIT:0] fp_n;
  logic                 done_n;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      sign_r    <= 1'b0;
      zero_r    <= 1'b0;
      exp_r     <= '0;
      frac_r    <= '0;
      fp_out    <= '0;
      done_tick <= 1'b0;
    end else begin
      state     <= state_n;
      sign_r    <= sign_n;
      zero_r    <= zero_n;
      exp_r     <= exp_n;
      frac_r    <= frac_n;
      fp_out    <= fp_n;
      done_tick <= done_n;
    end
  end

  assign ready = (state == IDLE);

`ifdef INT2FP_FAST_NORM_EN
  // Leading zeros of the magnitude held in frac_r[N_BIT-1:1]; later (higher) hits override earlier ones.
  logic [2:0] lz;
  always_comb begin
    lz = '0;
    for (int i = 0; i < N_BIT - 1; i++) begin
      if (frac_r[i+1]) lz = 3'(N_BIT - 2 - i);
    end
  end
`endif

  // NOTE: every combinational output is defaulted first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    state_n = state;
    sign_n  = sign_r;
    zero_n  = zero_r;
    exp_n   = exp_r;
    frac_n  = frac_r;
    fp_n    = fp_out;
    done_n  = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          sign_n  = int_in[N_BIT-1];
          frac_n  = {int_in[N_BIT-2:0], 1'b0};
          exp_n   = E_BIT'(N_BIT - 1);
          zero_n  = (int_in[N_BIT-2:0] == '0);
          state_n = NORM;
        end
      end
      NORM: begin
        if (zero_r) begin
          // Sign survives so -0 stays distinguishable downstream.
          fp_n    = {sign_r, {(N_BIT+E_BIT){1'b0}}};
          done_n  = 1'b1;
          state_n = IDLE;
        end else begin
`ifdef INT2FP_FAST_NORM_EN
          fp_n    = {sign_r, exp_r - E_BIT'(lz), frac_r << lz};
          done_n  = 1'b1;
          state_n = IDLE;
`else
          if (frac_r[N_BIT-1]) begin
            fp_n    = {sign_r, exp_r, frac_r};
            done_n  = 1'b1;
            state_n = IDLE;
          end else begin
            frac_n = frac_r << 1;
            exp_n  = exp_r - E_BIT'(1);
          end
`endif
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_int_to_fp_seq.sv
// Scoreboard bench for int_to_fp_seq: driver pushes reference results, a negedge monitor pops and compares.
module tb_int_to_fp_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [7:0]  int_in;
  logic        ready;
  logic        done_tick;
  logic [12:0] fp_out;

  int_to_fp_seq dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .int_in    (int_in),
    .ready     (ready),
    .done_tick (done_tick),
    .fp_out    (fp_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  val;
    logic [12:0] fp;
    int          lat;   // cycles inclusive of the start cycle and the done_tick cycle
    int          acc;   // edge number at which start was accepted
  } exp_t;

  exp_t        q[$];
  int          n_checks = 0;
  int          n_miss   = 0;
  int          cyc      = 0;
  logic [12:0] last_fp  = '0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: value = frac * 2^(exp-8) with frac[7]=1, exp = 1-based position of the leading one.
  function automatic exp_t ref_model(input logic [7:0] v);
    exp_t e;
    int mag, p;
    mag = int'(v[6:0]);
    p = 0;
    while ((1 << p) <= mag) p++;
    e.val = v;
    if (mag == 0) begin
      e.fp  = {v[7], 12'h000};
      e.lat = 2;
    end else begin
      e.fp  = {v[7], 4'(p), 8'(mag << (8 - p))};
`ifdef INT2FP_FAST_NORM_EN
      e.lat = 2;
`else
      e.lat = (7 - p) + 2;
`endif
    end
    e.acc = 0;
    return e;
  endfunction

  // Monitor: compares each completion against the scoreboard and checks fp_out holds otherwise.
  always @(negedge clk) begin
    if (!reset_n) begin
      last_fp = '0;
      check("done_in_reset", 32'(done_tick), 32'd0);
    end else if (done_tick) begin
      check("ready_on_done", 32'(ready), 32'd1);
      if (q.size() == 0) begin
        n_checks++;
        n_miss++;
        $display("FAIL unexpected_done: got fp_out 0x%0h, expected no completion (cycle %0d)", fp_out, cyc);
      end else begin
        exp_t e;
        int dexp, dmag;
        e = q.pop_front();
        check($sformatf("fp_out[%02h]", e.val), 32'(fp_out), 32'(e.fp));
        check($sformatf("latency[%02h]", e.val), cyc - e.acc + 1, e.lat);
        dexp = int'(fp_out[11:8]);
        dmag = (dexp == 0) ? 0 : (int'(fp_out[7:0]) >> (8 - dexp));
        check($sformatf("roundtrip[%02h]", e.val), {fp_out[12], 7'(dmag)}, 32'(e.val));
      end
      last_fp = fp_out;
    end else begin
      check("fp_hold", 32'(fp_out), 32'(last_fp));
    end
  end

  // Called at a negedge; waits (bounded) for ready, then presents start for one cycle.
  task automatic issue(input logic [7:0] v);
    exp_t e;
    int t = 0;
    while (!ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!ready) begin
      check("ready_timeout", 32'(ready), 32'd1);
    end else begin
      start  = 1'b1;
      int_in = v;
      e      = ref_model(v);
      e.acc  = cyc + 1;
      q.push_back(e);
      @(negedge clk);
      start  = 1'b0;
      int_in = 8'($urandom);
    end
  endtask

  task automatic wait_drain();
    int t = 0;
    while (q.size() != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("drain_timeout", q.size(), 0);
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    int_in  = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_ready", 32'(ready), 32'd1);
    check("reset_fp_out", 32'(fp_out), 32'd0);
    check("reset_done", 32'(done_tick), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Directed corner values: largest lz=0 case, smallest nonzero, mid, negative zero.
    issue(8'h40); wait_drain();
    issue(8'h81); wait_drain();
    issue(8'h05); wait_drain();
    issue(8'h80); wait_drain();

    // Start while busy is ignored; a start on the done cycle is accepted back-to-back.
    issue(8'h01);
    for (int i = 0; i < 3; i++) begin
      check("busy_ready", 32'(ready), 32'd0);
      start  = 1'b1;
      int_in = 8'h7F;
      @(negedge clk);
    end
    start = 1'b0;
    issue(8'hC0);
    issue(8'h23);
    wait_drain();

    // Async reset during the third NORM cycle of 8'h02 aborts the conversion.
    issue(8'h02);
    @(negedge clk);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    void'(q.pop_back());
    #1;
    check("abort_fp_out", 32'(fp_out), 32'd0);
    check("abort_done", 32'(done_tick), 32'd0);
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    check("abort_ready", 32'(ready), 32'd1);
    repeat (10) @(negedge clk);

    // Exhaustive sweep, back-to-back.
    for (int v = 0; v < 256; v++) issue(8'(v));
    wait_drain();

    // Randomized values, idle gaps and spurious busy starts.
    for (int n = 0; n < 150; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      issue(8'($urandom));
      if (($urandom % 2) == 1 && !ready) begin
        start  = 1'b1;
        int_in = 8'($urandom);
        @(negedge clk);
        start  = 1'b0;
      end
    end
    wait_drain();
    repeat (10) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_miss);
    $finish;
  end

endmodule

// File: doc/int_to_fp_seq.md
Name: int_to_fp_seq

Overview:
- Sequential sign-magnitude integer to simplified floating-point converter.
- Produces the 13-bit format {sign, exp[3:0], frac[7:0]} consumed by the fp-to-int stage.
- Normalization is iterative: one left-shift per clock under a start/done handshake.
- Sits directly upstream of the fp-to-int converter; fp_out feeds its fp_in.

Parameters:
- N_BIT, 8, integer width including sign bit; also the fraction width.
- E_BIT, 4, exponent width.
- Only the defaults are supported and verified.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request conversion of int_in; sampled only when ready=1.
- int_in  input  8  sign-magnitude integer: bit7 sign, [6:0] magnitude.
- ready  output  1  high when idle and able to accept start.
- done_tick  output  1  one-cycle pulse when fp_out is updated.
- fp_out  output  13  result: [12] sign, [11:8] exp, [7:0] frac; held until the next completion.

Behaviour:
- Format: value = frac * 2^(exp-8). Normalized frac has frac[7]=1 and exp = bit position (1..7) of the magnitude's leading one, so fp-to-int recovers magnitude = frac >> (8-exp). Zero is encoded as exp=0, frac=0.
- Reset (async, reset_n=0): state=IDLE, fp_out=0, done_tick=0, ready=1, internal regs=0.
- States: IDLE, NORM.
- IDLE:
  - ready=1.
  - On start=1 at a clock edge: latch sign=int_in[7], frac_r={int_in[6:0],1'b0}, exp_r=7, zero_r=(int_in[6:0]==0); go to NORM.
- NORM (ready=0):
  - If zero_r: fp_out<={sign,4'd0,8'd0}, done_tick<=1, go to IDLE. Sign is preserved, so -0 gives 13'h1000.
  - Else if frac_r[7]=1: fp_out<={sign,exp_r,frac_r}, done_tick<=1, go to IDLE.
  - Else: frac_r<=frac_r<<1, exp_r<=exp_r-1, stay in NORM.
- Latency: start edge to the edge registering done_tick = lz+2 cycles, where lz = leading zeros of the 7-bit magnitude (0..6). Zero input takes 2 cycles. Range is 2..8.
- exp_r never drops below 1 for nonzero input; no underflow or overflow is possible, and no flags are output.
- done_tick is registered and high for exactly one cycle. ready rises in the same cycle as done_tick.
- start while ready=0 is ignored; it is not queued.
- start asserted in the same cycle done_tick is high is accepted, since ready=1. Back-to-back throughput is one conversion per lz+2 cycles.
- fp_out changes only on completion. It is stable between done_tick pulses and while a new conversion is in progress.
- Reset asserted mid-conversion aborts immediately:
  - No done_tick.
  - fp_out returns to 0.
  - ready=1 after reset_n deasserts.

Optional Feature:
- Macro: INT2FP_FAST_NORM_EN.
- Defined:
  - NORM performs full normalization in one cycle using a 7-bit leading-one priority encoder and barrel shift.
  - Latency is fixed at 2 cycles for all inputs.
  - Results are identical to the iterative version.
- Undefined: the iterative one-bit-per-cycle behaviour above applies. No priority encoder is synthesized.

Test Plan:
- int_in=8'h40 (+64), start pulse -> done_tick 2 cycles later, fp_out=13'h0780 (exp 7, frac 0x80).
- int_in=8'h81 (-1) -> done_tick 8 cycles after start, fp_out=13'h1180. With INT2FP_FAST_NORM_EN: 2 cycles, same value.
- int_in=8'h05 (+5) -> done_tick after 6 cycles, fp_out=13'h03A0. Then int_in=8'h80 (-0) -> 2 cycles, fp_out=13'h1000.
- Start 8'h01, pulse start again with 8'h7F on cycles 2-4 -> second start ignored; fp_out=13'h0180, ready=0 throughout. A start on the done_tick cycle is accepted.
- Drop reset_n during the third NORM cycle of a conversion of 8'h02 -> fp_out=0 and done_tick=0 immediately; ready=1 after release; no done_tick is ever produced for that conversion.
- Exhaustive: all 256 int_in values chained through the fp-to-int stage -> its int_out equals int_in, uf=of=0, done_tick count=256.
